// File: rtl/apb_uart.sv
// apb_uart: APB slave UART with TX/RX FIFOs, integer baud divisor and an oversampled receiver.
// Register map follows the PL011 layout; modem control, IrDA and DMA are not provided.
module apb_uart #(
   parameter int FIFO_DEPTH = 16,
   parameter int OVS        = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [9:0]  PADDR,
   input  logic [15:0] PWDATA,
   output logic [15:0] PRDATA,
   input  logic        UARTRXD,
   output logic        UARTTXD,
   output logic        UARTRXINTR,
   output logic        UARTTXINTR,
   output logic        UARTRTINTR,
   output logic        UARTEINTR,
   output logic        UARTINTR
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(OVS);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
   localparam logic [9:0] A_DR = 10'd0, A_RSR = 10'd1, A_FR = 10'd6, A_IBRD = 10'd9, A_LCRH = 10'd11;
   localparam logic [9:0] A_CR = 10'd12, A_IMSC = 10'd14, A_RIS = 10'd15, A_MIS = 10'd16, A_ICR = 10'd17;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

   logic [15:0] ibrd_q, baud_q;
   logic [6:0]  lcr_q, imsc_q;
   logic        cr_en_q, cr_txe_q, cr_rxe_q;
   logic [3:0]  rsr_q;
   logic [4:0]  ris_q;
   logic        oe_pend_q;
   logic        apb_wr, apb_rd, dr_rd, tick;
   logic        brk, pen, eps, stp2, fen;
   logic [1:0]  wlen;
   logic [2:0]  last_bit;
   logic [7:0]  wmask;
   logic [10:0] ris, mis;

   assign apb_wr = PSEL & PENABLE & PWRITE;
   assign apb_rd = PSEL & PENABLE & ~PWRITE;
   assign dr_rd  = apb_rd && PADDR == A_DR;
   assign {wlen, fen, stp2, eps, pen, brk} = lcr_q;
   assign last_bit = 3'd4 + {1'b0, wlen};
   assign wmask = 8'hff >> (2'd3 - wlen);

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         ibrd_q   <= '0;
         lcr_q    <= '0;
         imsc_q   <= '0;
         cr_en_q  <= 1'b0;
         cr_txe_q <= 1'b1;
         cr_rxe_q <= 1'b1;
      end else if (apb_wr) begin
         if (PADDR == A_IBRD) ibrd_q <= PWDATA;
         if (PADDR == A_LCRH) lcr_q <= PWDATA[6:0];
         if (PADDR == A_IMSC) imsc_q <= PWDATA[10:4];
         if (PADDR == A_CR) {cr_rxe_q, cr_txe_q, cr_en_q} <= {PWDATA[9:8], PWDATA[0]};
      end

   // >= rather than == so that shrinking IBRD below the running count cannot stall the divider
   assign tick = cr_en_q && ibrd_q != 16'h0 && baud_q >= ibrd_q - 16'd1;

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) baud_q <= '0;
      else baud_q <= (!cr_en_q || ibrd_q == 16'h0 || tick) ? 16'h0 : baud_q + 16'd1;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [11:0]   rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [CW-1:0] tx_cnt_q, rx_cnt_q;
   logic          tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    tx_head;
   logic [11:0]   rx_head, rx_wdata;

   assign tx_empty = tx_cnt_q == '0;
   assign rx_empty = rx_cnt_q == '0;
   assign tx_full  = fen ? tx_cnt_q == CW'(FIFO_DEPTH) : !tx_empty;
   assign rx_full  = fen ? rx_cnt_q == CW'(FIFO_DEPTH) : !rx_empty;
   assign tx_head  = tx_mem[tx_rp_q];
   assign rx_head  = rx_mem[rx_rp_q];
   assign tx_push  = apb_wr && PADDR == A_DR && !tx_full;
   assign rx_pop   = dr_rd && !rx_empty;

   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wp_q] <= PWDATA[7:0];
      if (rx_push) rx_mem[rx_wp_q] <= rx_wdata;
   end

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_wp_q  <= tx_wp_q + AW'(tx_push);
         tx_rp_q  <= tx_rp_q + AW'(tx_pop);
         tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
         rx_wp_q  <= rx_wp_q + AW'(rx_push);
         rx_rp_q  <= rx_rp_q + AW'(rx_pop);
         rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      end

   state_t        tx_st_q;
   logic [7:0]    tx_sh_q;
   logic          tx_par_q, txd_q;
   logic [TW-1:0] tx_tc_q;
   logic [2:0]    tx_bit_q;

   assign tx_pop = tx_st_q == S_IDLE && cr_en_q && cr_txe_q && !tx_empty;

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         tx_st_q  <= S_IDLE;
         tx_sh_q  <= '0;
         tx_par_q <= 1'b0;
         txd_q    <= 1'b1;
         tx_tc_q  <= '0;
         tx_bit_q <= '0;
      end else if (tx_st_q == S_IDLE) begin
         if (tx_pop) begin
            tx_st_q  <= S_START;
            tx_sh_q  <= tx_head;
            tx_par_q <= ^(tx_head & wmask) ^ ~eps;
            txd_q    <= 1'b0;
            tx_tc_q  <= '0;
            tx_bit_q <= '0;
         end
      end else if (tick) begin
         tx_tc_q <= tx_tc_q + 1'b1;
         if (tx_tc_q == T_LAST)
            case (tx_st_q)
               S_START: begin
                  tx_st_q <= S_DATA;
                  txd_q   <= tx_sh_q[0];
                  tx_sh_q <= tx_sh_q >> 1;
               end
               S_DATA:
                  if (tx_bit_q == last_bit) begin
                     tx_st_q  <= pen ? S_PAR : S_STOP;
                     txd_q    <= pen ? tx_par_q : 1'b1;
                     tx_bit_q <= '0;
                  end else begin
                     tx_bit_q <= tx_bit_q + 1'b1;
                     txd_q    <= tx_sh_q[0];
                     tx_sh_q  <= tx_sh_q >> 1;
                  end
               S_PAR: begin
                  tx_st_q <= S_STOP;
                  txd_q   <= 1'b1;
               end
               default:
                  if (stp2 && tx_bit_q == 3'd0) tx_bit_q <= 3'd1;
                  else tx_st_q <= S_IDLE;
            endcase
      end

   state_t        rx_st_q;
   logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_par_q;
   logic [7:0]    rx_sh_q;
   logic [TW-1:0] rx_tc_q;
   logic [2:0]    rx_bit_q;
   logic          rx_start, rx_done, rx_fe, rx_pe, rx_brk;

   assign rx_start = rx_st_q == S_IDLE && cr_en_q && cr_rxe_q && rx_prev_q && !rx_s2_q;
   assign rx_done  = rx_st_q == S_STOP && tick && rx_tc_q == T_LAST;
   assign rx_fe    = !rx_s2_q;
   assign rx_brk   = rx_fe && rx_sh_q == 8'h0 && !(pen && rx_par_q);
   assign rx_pe    = pen && !rx_brk && (rx_par_q != (^rx_sh_q ^ ~eps));
   assign rx_push  = rx_done && !rx_full;
   // an overrun is flagged on the next character that does make it into the FIFO
   assign rx_wdata = {oe_pend_q, rx_brk, rx_pe, rx_fe, rx_sh_q};

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= S_IDLE;
         rx_sh_q   <= '0;
         rx_par_q  <= 1'b0;
         rx_tc_q   <= '0;
         rx_bit_q  <= '0;
         oe_pend_q <= 1'b0;
      end else begin
         rx_s1_q   <= UARTRXD;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         oe_pend_q <= rx_done ? rx_full : oe_pend_q;
         case (rx_st_q)
            S_IDLE:
               if (rx_start) begin
                  rx_st_q  <= S_START;
                  rx_tc_q  <= '0;
                  rx_sh_q  <= '0;
                  rx_par_q <= 1'b0;
                  rx_bit_q <= '0;
               end
            S_BRK: if (rx_s2_q) rx_st_q <= S_IDLE;
            default:
               if (tick) begin
                  rx_tc_q <= rx_tc_q + 1'b1;
                  if (rx_st_q == S_START && rx_tc_q == T_MID) begin
                     rx_st_q <= rx_s2_q ? S_IDLE : S_DATA;
                     rx_tc_q <= '0;
                  end else if (rx_tc_q == T_LAST)
                     case (rx_st_q)
                        S_DATA: begin
                           rx_sh_q[rx_bit_q] <= rx_s2_q;
                           rx_bit_q <= rx_bit_q + 1'b1;
                           if (rx_bit_q == last_bit) rx_st_q <= pen ? S_PAR : S_STOP;
                        end
                        S_PAR: begin
                           rx_par_q <= rx_s2_q;
                           rx_st_q  <= S_STOP;
                        end
                        default: rx_st_q <= rx_brk ? S_BRK : S_IDLE;
                     endcase
               end
         endcase
      end

   logic [8:0] rt_cnt_q;
   logic       rt_hold, rt_fire, ovf;
   logic [4:0] ris_set, ris_clr;

   assign ovf     = rx_done && rx_full;
   assign rt_hold = rx_empty || rx_st_q != S_IDLE || dr_rd;
   assign rt_fire = !rt_hold && tick && rt_cnt_q == 9'h1ff;
   assign ris_set = {ovf, rx_done && rx_brk, rx_done && rx_pe, rx_done && rx_fe, rt_fire};
   assign ris_clr = ((apb_wr && PADDR == A_ICR) ? PWDATA[10:6] : 5'h0) | {4'h0, dr_rd};

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         rt_cnt_q <= '0;
         ris_q    <= '0;
         rsr_q    <= '0;
      end else begin
         rt_cnt_q <= rt_hold ? 9'h0 : rt_cnt_q + 9'(tick);
         ris_q    <= (ris_q & ~ris_clr) | ris_set;
         if (apb_wr && PADDR == A_RSR) rsr_q <= '0;
         else if (rx_pop) rsr_q <= {rsr_q[3] | rx_head[11] | ovf, rx_head[10:8]};
         else if (ovf) rsr_q[3] <= 1'b1;
      end

   assign ris = {ris_q,
                 fen ? tx_cnt_q <= CW'(FIFO_DEPTH / 2) : tx_empty,
                 fen ? rx_cnt_q >= CW'(FIFO_DEPTH / 2) : !rx_empty,
                 4'h0};
   assign mis = ris & {imsc_q, 4'h0};

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE)
         case (PADDR)
            A_DR:    PRDATA = rx_empty ? 16'h0 : {4'h0, rx_head};
            A_RSR:   PRDATA = {12'h0, rsr_q};
            A_FR:    PRDATA = {8'h0, tx_empty, rx_full, tx_full, rx_empty, tx_st_q != S_IDLE || !tx_empty, 3'h0};
            A_IBRD:  PRDATA = ibrd_q;
            A_LCRH:  PRDATA = {9'h0, lcr_q};
            A_CR:    PRDATA = {6'h0, cr_rxe_q, cr_txe_q, 7'h0, cr_en_q};
            A_IMSC:  PRDATA = {5'h0, imsc_q, 4'h0};
            A_RIS:   PRDATA = {5'h0, ris};
            A_MIS:   PRDATA = {5'h0, mis};
            default: PRDATA = '0;
         endcase
   end

   assign UARTTXD    = txd_q & ~brk;
   assign UARTRXINTR = mis[4];
   assign UARTTXINTR = mis[5];
   assign UARTRTINTR = mis[6];
   assign UARTEINTR  = |mis[10:7];
   assign UARTINTR   = |mis[10:4];
endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: randomized bench for apb_uart; serial frames are modelled as plain bit lists.
module tb_apb_uart;
   logic        PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [9:0]  PADDR = '0;
   logic [15:0] PWDATA = '0, PRDATA;
   logic        UARTRXD = 1'b1, UARTTXD, UARTRXINTR, UARTTXINTR, UARTRTINTR, UARTEINTR, UARTINTR;
   int checks = 0, failures = 0;

   apb_uart dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .UARTRXD(UARTRXD), .UARTTXD(UARTTXD),
      .UARTRXINTR(UARTRXINTR), .UARTTXINTR(UARTTXINTR), .UARTRTINTR(UARTRTINTR),
      .UARTEINTR(UARTEINTR), .UARTINTR(UARTINTR)
   );

   always #5 PCLK = ~PCLK;

   task automatic apb_write(input logic [11:0] a, input logic [15:0] d);
      @(negedge PCLK);
      PSEL = 1; PWRITE = 1; PADDR = a[11:2]; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1;
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [15:0] d);
      @(negedge PCLK);
      PSEL = 1; PWRITE = 0; PADDR = a[11:2];
      @(negedge PCLK);
      PENABLE = 1;
      d = PRDATA;
      @(negedge PCLK);
      PSEL = 0; PENABLE = 0;
   endtask

   // Serial frame as a list of line levels: start, data LSB first, parity, stops.
   function automatic int frame_bits(input logic [7:0] d, input int nb, input bit pen, input bit eps,
                                     input int nstop, output logic [15:0] b);
      int n = 1, ones = 0;
      b = '1;
      b[0] = 1'b0;
      for (int i = 0; i < nb; i++) begin
         b[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (pen) begin
         b[n] = ((ones % 2) == 1) ^ !eps;
         n++;
      end
      return n + nstop;
   endfunction

   function automatic logic [15:0] exp_dr(input logic [7:0] d, input int nb, input bit pen, input bit eps,
                                          input bit bad_par, input bit stop);
      logic [15:0] b;
      logic [7:0] dm;
      logic pb;
      void'(frame_bits(d, nb, pen, eps, 1, b));
      dm = d & 8'((1 << nb) - 1);
      pb = pen ? b[nb+1] ^ bad_par : 1'b0;
      if (dm == 8'h0 && !pb && !stop) return 16'h0500;
      return {6'h0, pen & bad_par, !stop, dm};
   endfunction

   task automatic send_rx(input logic [7:0] d, input int nb, input bit pen, input bit eps,
                          input bit bad_par, input bit stop, input int bc);
      logic [15:0] b;
      int n;
      n = frame_bits(d, nb, pen, eps, 1, b);
      if (pen) b[nb+1] = b[nb+1] ^ bad_par;
      b[n-1] = stop;
      for (int i = 0; i < n; i++) begin
         UARTRXD = b[i];
         repeat (bc) @(negedge PCLK);
      end
      UARTRXD = 1'b1;
      repeat (bc) @(negedge PCLK);
   endtask

   task automatic capture_tx(input int n, input int bc, output logic [15:0] got);
      int t = 0;
      got = '1;
      while (UARTTXD !== 1'b0 && t < 40 * bc) begin
         @(negedge PCLK);
         t++;
      end
      if (UARTTXD === 1'b0) begin
         repeat (bc / 2) @(negedge PCLK);
         for (int i = 0; i < n; i++) begin
            got[i] = UARTTXD;
            if (i < n - 1) repeat (bc) @(negedge PCLK);
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] r;
      apb_read(12'h018, r); checks++;
      if (r !== 16'h0090) begin failures++; $display("FAIL reset_fr: got %h want 0090", r); end
      apb_read(12'h030, r); checks++;
      if (r !== 16'h0300) begin failures++; $display("FAIL reset_cr: got %h want 0300", r); end
      apb_read(12'h02C, r); checks++;
      if (r !== 16'h0000) begin failures++; $display("FAIL reset_lcrh: got %h want 0000", r); end
      apb_read(12'h03C, r); checks++;
      if (r !== 16'h0020) begin failures++; $display("FAIL reset_ris: got %h want 0020", r); end
      checks++;
      if (UARTTXD !== 1'b1 || UARTINTR !== 1'b0) begin
         failures++; $display("FAIL reset_pins: txd=%b intr=%b want 1 0", UARTTXD, UARTINTR);
      end
   endtask

   task automatic test_rx_basic();
      logic [15:0] r;
      apb_write(12'h024, 16'd54);
      apb_write(12'h02C, 16'h0070);
      apb_write(12'h030, 16'h0301);
      send_rx(8'hA5, 8, 0, 0, 0, 1, 16 * 54);
      apb_read(12'h018, r); checks++;
      if (r[4] !== 1'b0) begin failures++; $display("FAIL rx_rxfe: got %b want 0", r[4]); end
      apb_read(12'h000, r); checks++;
      if (r !== exp_dr(8'hA5, 8, 0, 0, 0, 1)) begin failures++; $display("FAIL rx_dr: got %h want 00a5", r); end
      apb_read(12'h004, r); checks++;
      if (r !== 16'h0000) begin failures++; $display("FAIL rx_rsr: got %h want 0000", r); end
   endtask

   task automatic test_rx_errors();
      logic [15:0] r;
      apb_write(12'h024, 16'd3);
      apb_write(12'h02C, 16'h0066);
      send_rx(8'h3C, 8, 1, 1, 1, 1, 48);
      apb_read(12'h000, r); checks++;
      if (r !== exp_dr(8'h3C, 8, 1, 1, 1, 1)) begin failures++; $display("FAIL par_dr: got %h want 023c", r); end
      apb_read(12'h03C, r); checks++;
      if (r[8] !== 1'b1) begin failures++; $display("FAIL par_ris: got %b want 1", r[8]); end
      apb_write(12'h038, 16'h0100); checks++;
      if (UARTEINTR !== 1'b1) begin failures++; $display("FAIL par_eintr: got %b want 1", UARTEINTR); end
      apb_write(12'h044, 16'h0100); checks++;
      if (UARTEINTR !== 1'b0) begin failures++; $display("FAIL par_icr: got %b want 0", UARTEINTR); end
      send_rx(8'h5A, 8, 1, 1, 0, 0, 48);
      apb_read(12'h000, r); checks++;
      if (r !== exp_dr(8'h5A, 8, 1, 1, 0, 0)) begin failures++; $display("FAIL fe_dr: got %h want 015a", r); end
      UARTRXD = 1'b0;
      repeat (12 * 48) @(negedge PCLK);
      UARTRXD = 1'b1;
      repeat (2 * 48) @(negedge PCLK);
      apb_read(12'h000, r); checks++;
      if (r !== 16'h0500) begin failures++; $display("FAIL brk_dr: got %h want 0500", r); end
      apb_write(12'h044, 16'h07FF);
      apb_write(12'h038, 16'h0000);
   endtask

   task automatic test_rx_random();
      logic [15:0] r, e;
      for (int k = 0; k < 8; k++) begin
         logic [7:0] d = 8'($urandom);
         int wl = int'($urandom_range(0, 3));
         bit pen = 1'($urandom), eps = 1'($urandom), bad = ($urandom_range(0, 3) == 0);
         bit stop = ($urandom_range(0, 3) != 0);
         apb_write(12'h02C, 16'((wl << 5) | 16 | (int'(eps) << 2) | (int'(pen) << 1)));
         send_rx(d, 5 + wl, pen, eps, bad, stop, 48);
         e = exp_dr(d, 5 + wl, pen, eps, bad, stop);
         apb_read(12'h000, r); checks++;
         if (r !== e) begin failures++; $display("FAIL rx_rand%0d: got %h want %h", k, r, e); end
      end
      apb_write(12'h044, 16'h07FF);
   endtask

   task automatic test_tx_basic();
      logic [15:0] got, e, r;
      int n, t = 0;
      apb_write(12'h024, 16'd54);
      apb_write(12'h02C, 16'h0070);
      n = frame_bits(8'h55, 8, 0, 0, 1, e);
      fork
         apb_write(12'h000, 16'h0055);
         capture_tx(n, 16 * 54, got);
      join
      checks++;
      if (got !== e) begin failures++; $display("FAIL tx_55: got %b want %b", got[9:0], e[9:0]); end
      r = 16'hFFFF;
      while (r[3] !== 1'b0 && t < 600) begin apb_read(12'h018, r); t++; end
      checks++;
      if (r !== 16'h0090) begin failures++; $display("FAIL tx_busy: fr got %h want 0090", r); end
   endtask

   task automatic test_tx_random();
      logic [15:0] got, e;
      int n;
      apb_write(12'h024, 16'd3);
      for (int k = 0; k < 6; k++) begin
         logic [7:0] d = 8'($urandom);
         int wl = int'($urandom_range(0, 3));
         bit pen = 1'($urandom), eps = 1'($urandom), s2 = 1'($urandom);
         apb_write(12'h02C, 16'((wl << 5) | 16 | (int'(s2) << 3) | (int'(eps) << 2) | (int'(pen) << 1)));
         n = frame_bits(d, 5 + wl, pen, eps, s2 ? 2 : 1, e);
         fork
            apb_write(12'h000, {8'h0, d});
            capture_tx(n, 48, got);
         join
         checks++;
         if (got !== e) begin failures++; $display("FAIL tx_rand%0d: got %b want %b", k, got, e); end
         repeat (48) @(negedge PCLK);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got [3], e [3];
      logic [7:0] d [3];
      apb_write(12'h02C, 16'h0070);
      for (int i = 0; i < 3; i++) begin
         d[i] = 8'($urandom);
         void'(frame_bits(d[i], 8, 0, 0, 1, e[i]));
      end
      fork
         for (int i = 0; i < 3; i++) apb_write(12'h000, {8'h0, d[i]});
         for (int j = 0; j < 3; j++) capture_tx(10, 48, got[j]);
      join
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== e[i]) begin failures++; $display("FAIL b2b%0d: got %b want %b", i, got[i], e[i]); end
      end
      repeat (96) @(negedge PCLK);
   endtask

   task automatic test_overflow();
      logic [7:0] q [$];
      logic [15:0] r;
      int t = 0;
      apb_write(12'h02C, 16'h0070);
      for (int i = 0; i < 17; i++) begin
         q.push_back(8'($urandom));
         send_rx(q[i], 8, 0, 0, 0, 1, 48);
      end
      apb_read(12'h018, r); checks++;
      if (r[6] !== 1'b1) begin failures++; $display("FAIL ovf_rxff: got %b want 1", r[6]); end
      apb_read(12'h03C, r); checks++;
      if (r[10] !== 1'b1 || r[4] !== 1'b1) begin failures++; $display("FAIL ovf_ris: got %h want bits 10,4 set", r); end
      apb_read(12'h000, r); checks++;
      if (r !== {8'h0, q[0]}) begin failures++; $display("FAIL ovf_first: got %h want %h", r, {8'h0, q[0]}); end
      apb_read(12'h004, r); checks++;
      if (r !== 16'h0008) begin failures++; $display("FAIL ovf_rsr: got %h want 0008", r); end
      r = '0;
      while (r[6] !== 1'b1 && t < 1500) begin apb_read(12'h03C, r); t++; end
      checks++;
      if (r[6] !== 1'b1) begin failures++; $display("FAIL rt_set: got %b want 1", r[6]); end
      for (int i = 1; i < 16; i++) begin
         apb_read(12'h000, r); checks++;
         if (r !== {8'h0, q[i]}) begin failures++; $display("FAIL ovf_drain%0d: got %h want %h", i, r, {8'h0, q[i]}); end
      end
      apb_read(12'h03C, r); checks++;
      if (r[6] !== 1'b0) begin failures++; $display("FAIL rt_clr: got %b want 0", r[6]); end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] r;
      apb_write(12'h000, 16'h0000);
      repeat (150) @(negedge PCLK);
      checks++;
      if (UARTTXD !== 1'b0) begin failures++; $display("FAIL mid_busy: txd got %b want 0", UARTTXD); end
      PRESETn = 0;
      #1; checks++;
      if (UARTTXD !== 1'b1) begin failures++; $display("FAIL mid_txd: got %b want 1", UARTTXD); end
      repeat (3) @(negedge PCLK);
      PRESETn = 1;
      apb_read(12'h018, r); checks++;
      if (r !== 16'h0090) begin failures++; $display("FAIL mid_fr: got %h want 0090", r); end
      apb_read(12'h024, r); checks++;
      if (r !== 16'h0000) begin failures++; $display("FAIL mid_ibrd: got %h want 0000", r); end
      repeat (200) @(negedge PCLK); checks++;
      if (UARTTXD !== 1'b1) begin failures++; $display("FAIL mid_idle: txd got %b want 1", UARTTXD); end
   endtask

   initial begin
      repeat (5) @(negedge PCLK);
      PRESETn = 1;
      test_reset();
      test_rx_basic();
      test_rx_errors();
      test_rx_random();
      test_tx_basic();
      test_tx_random();
      test_back_to_back();
      test_overflow();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
